sampler_source: RTL and testbench

Candidate-stimulus source for the constraint-sampling flow. It generates pseudo-random packed candidate vectors from a seeded LFSR and drives them into the generated combinational constraint checker. It reads back the checker's single satisfied bit and buffers satisfying candidates in an output FIFO behind a valid/ready handshake. It stops after a requested number of accepted samples or a try budget, whichever comes first.

---
 rtl/sampler_source.sv | 267 ++++++++++++++++++++++++++
 tb/tb_sampler_source.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sampler_source.sv
// sampler_source
//   Candidate-stimulus source for the constraint-sampling flow. A seeded
//   32-bit Fibonacci LFSR fills a VEC_W-bit candidate 32 bits per cycle. The
//   candidate is handed to an external combinational constraint checker. When
//   the checker reports it satisfied, the candidate is buffered in an output
//   FIFO with a valid/ready handshake. A run ends after num_samples accepted
//   candidates or after max_tries evaluated candidates, whichever is first.
//
//   Optional feature macro: SAMPLER_DEDUP_EN. When it is defined, a satisfying
//   candidate equal to the previously pushed one is rejected as a plain try.
//
// Parameters
//   VEC_W      candidate width (var_0 at the LSBs)
//   FIFO_DEPTH output FIFO entries (power of two, >= 2)
//   TRY_W      width of the try budget and the try counter
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   start         one-cycle run request, honoured in IDLE or DONE only
//   seed          LFSR seed (0 is loaded as 1)
//   num_samples   accepted samples required for the run
//   max_tries     candidate budget for the run
//   cand          candidate driven to the checker
//   sat           checker result for cand
//   out_valid     FIFO non-empty
//   out_ready     consumer accepts the head entry
//   out_data      registered FIFO head
//   busy          high while filling or checking
//   done          high once the run has finished, until the next start
//   timeout       the run ended by exhausting max_tries
//   tries_cnt     candidates evaluated in the current run (saturating)
//   accept_cnt    candidates pushed in the current run (saturating)
module sampler_source #(
  parameter int VEC_W      = 307,
  parameter int FIFO_DEPTH = 8,
  parameter int TRY_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      seed,
  input  logic [15:0]      num_samples,
  input  logic [TRY_W-1:0] max_tries,
  output logic [VEC_W-1:0] cand,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [VEC_W-1:0] out_data,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [TRY_W-1:0] tries_cnt,
  output logic [15:0]      accept_cnt
);

  localparam int K      = (VEC_W + 31) / 32;
  localparam int FILL_W = (K > 1) ? $clog2(K) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, FILL, CHECK, DONE} state_t;

  state_t state, state_nx;

  logic [31:0]       lfsr;
  logic [31:0]       lfsr_next;
  logic [VEC_W-1:0]  cand_shift;
  logic [FILL_W-1:0] fill_cnt;
  logic              fill_last;
  logic [15:0]       num_samples_r;
  logic [TRY_W-1:0]  max_tries_r;

  logic              start_ok;
  logic              zero_req;
  logic              sat_eff;
  logic              push;
  logic              reject;
  logic              pop;
  logic              last_sample;
  logic              last_try;
  logic [16:0]       accept_p1;
  logic [TRY_W:0]    tries_p1;

  logic [VEC_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_ptr_nx;
  logic [CNT_W-1:0]  fifo_cnt, fifo_cnt_nx;
  logic              fifo_full;
  logic [VEC_W-1:0]  head_nx;

  function automatic logic [TRY_W-1:0] inc_try(input logic [TRY_W-1:0] v);
    return (&v) ? v : v + TRY_W'(1);
  endfunction

  function automatic logic [15:0] inc_acc(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  // LFSR feedback taps 31, 21, 1, 0; the new bit enters at the LSB.
  assign lfsr_next = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};

  // Newest word lands in the low 32 bits; older words move up and fall off.
  generate
    if (VEC_W > 32) begin : g_wide
      assign cand_shift = {cand[VEC_W-33:0], lfsr_next};
    end else begin : g_narrow
      assign cand_shift = lfsr_next[VEC_W-1:0];
    end
  endgenerate

  assign fill_last = (fill_cnt == FILL_W'(K - 1));
  assign start_ok  = start && ((state == IDLE) || (state == DONE));
  assign zero_req  = (num_samples == 16'd0) || (max_tries == '0);

`ifdef SAMPLER_DEDUP_EN
  logic [VEC_W-1:0] last_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_acc <= '0;
    end else if (start_ok) begin
      last_acc <= '0;
    end else if (push) begin
      last_acc <= cand;
    end
  end

  // A repeat of the last pushed candidate behaves exactly like a miss.
  assign sat_eff = sat && (cand != last_acc);
`else
  assign sat_eff = sat;
`endif

  assign fifo_full = (fifo_cnt == CNT_W'(FIFO_DEPTH));
  assign push      = (state == CHECK) && sat_eff && !fifo_full;
  assign reject    = (state == CHECK) && !sat_eff;
  assign pop       = out_valid && out_ready;

  // Compare one bit wider so a budget of all-ones cannot wrap to zero.
  assign accept_p1   = {1'b0, accept_cnt} + 17'd1;
  assign tries_p1    = {1'b0, tries_cnt} + (TRY_W + 1)'(1);
  assign last_sample = (accept_p1 == {1'b0, num_samples_r});
  assign last_try    = (tries_p1 == {1'b0, max_tries_r});

  // ---- state register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: begin
        if (start_ok) begin
          state_nx = zero_req ? DONE : FILL;
        end
      end
      FILL: begin
        if (fill_last) begin
          state_nx = CHECK;
        end
      end
      CHECK: begin
        // Sample count wins over the budget on the same try.
        if (push) begin
          state_nx = (last_sample || last_try) ? DONE : FILL;
        end else if (reject) begin
          state_nx = last_try ? DONE : FILL;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // ---- output logic ----
  always_comb begin
    busy = (state == FILL) || (state == CHECK);
    done = (state == DONE);
  end

  // ---- run control, LFSR, candidate, counters ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr          <= 32'd1;
      cand          <= '0;
      fill_cnt      <= '0;
      num_samples_r <= '0;
      max_tries_r   <= '0;
      tries_cnt     <= '0;
      accept_cnt    <= '0;
      timeout       <= 1'b0;
    end else if (start_ok) begin
      lfsr          <= (seed == 32'd0) ? 32'd1 : seed;
      num_samples_r <= num_samples;
      max_tries_r   <= max_tries;
      tries_cnt     <= '0;
      accept_cnt    <= '0;
      timeout       <= 1'b0;
      fill_cnt      <= '0;
    end else begin
      case (state)
        FILL: begin
          lfsr     <= lfsr_next;
          cand     <= cand_shift;
          fill_cnt <= fill_last ? '0 : fill_cnt + FILL_W'(1);
        end
        CHECK: begin
          if (push) begin
            tries_cnt  <= inc_try(tries_cnt);
            accept_cnt <= inc_acc(accept_cnt);
            if (!last_sample && last_try) begin
              timeout <= 1'b1;
            end
          end else if (reject) begin
            tries_cnt <= inc_try(tries_cnt);
            if (last_try) begin
              timeout <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // ---- output FIFO ----
  // The head register is reloaded every cycle from the post-update pointer;
  // when the slot being written becomes the head, cand is bypassed in.
  assign rd_ptr_nx   = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
  assign fifo_cnt_nx = fifo_cnt + CNT_W'(push) - CNT_W'(pop);

  always_comb begin
    head_nx = '0;
    if (fifo_cnt_nx != '0) begin
      head_nx = (push && (wr_ptr == rd_ptr_nx)) ? cand : mem[rd_ptr_nx];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= cand;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      out_data <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      rd_ptr   <= rd_ptr_nx;
      fifo_cnt <= fifo_cnt_nx;
      out_data <= head_nx;
    end
  end

  assign out_valid = (fifo_cnt != '0);

endmodule

// File: tb/tb_sampler_source.sv
// Testbench for sampler_source. A behavioural model computes the candidate
// stream, accepted entries and final counters of each run; the bench drives
// the checker's sat input from a selectable rule and compares.
module tb_sampler_source;

  localparam int VEC_W      = 307;
  localparam int FIFO_DEPTH = 8;
  localparam int TRY_W      = 16;
  localparam int K          = (VEC_W + 31) / 32;

  logic             clk;
  logic             rst;
  logic             start;
  logic [31:0]      seed;
  logic [15:0]      num_samples;
  logic [TRY_W-1:0] max_tries;
  logic [VEC_W-1:0] cand;
  logic             sat;
  logic             out_valid;
  logic             out_ready;
  logic [VEC_W-1:0] out_data;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [TRY_W-1:0] tries_cnt;
  logic [15:0]      accept_cnt;

  sampler_source #(
    .VEC_W(VEC_W), .FIFO_DEPTH(FIFO_DEPTH), .TRY_W(TRY_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed),
    .num_samples(num_samples), .max_tries(max_tries), .cand(cand),
    .sat(sat), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy), .done(done), .timeout(timeout),
    .tries_cnt(tries_cnt), .accept_cnt(accept_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0: never satisfied, 1: always satisfied, 2: satisfied when cand[0]
  int sat_mode;
  always_comb begin
    case (sat_mode)
      0:       sat = 1'b0;
      1:       sat = 1'b1;
      default: sat = cand[0];
    endcase
  end

  int n_pass  = 0;
  int n_total = 0;

  logic [VEC_W-1:0] got_q[$];
  logic [VEC_W-1:0] exp_q[$];
  int exp_tries, exp_acc, exp_to;

  task automatic chk(input string tag, input logic [VEC_W-1:0] obs, input logic [VEC_W-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  // Reference: each candidate is K successive LFSR words, the most recent
  // word at bit 0 and earlier words above it, cut to VEC_W bits.
  task automatic model_run(input logic [31:0] sd, input int ns, input int mt, input int smode);
    logic [31:0]      s;
    logic [31:0]      w [K];
    logic [VEC_W-1:0] c;
    logic [VEC_W-1:0] last;
    bit               ok;
    exp_q.delete();
    exp_tries = 0;
    exp_acc   = 0;
    exp_to    = 0;
    if (ns == 0 || mt == 0) return;
    s    = (sd == 32'd0) ? 32'd1 : sd;
    last = '0;
    while (1) begin
      for (int k = 0; k < K; k++) begin
        s    = lfsr_step(s);
        w[k] = s;
      end
      for (int b = 0; b < VEC_W; b++) c[b] = w[K - 1 - b / 32][b % 32];
      ok = (smode == 1) || (smode == 2 && c[0]);
`ifdef SAMPLER_DEDUP_EN
      if (c == last) ok = 1'b0;
`endif
      exp_tries++;
      if (ok) begin
        exp_q.push_back(c);
        last = c;
        exp_acc++;
        if (exp_acc == ns) break;
      end
      if (exp_tries == mt) begin
        exp_to = 1;
        break;
      end
    end
  endtask

  // One run: start at an edge, then watch every cycle until done with the
  // FIFO drained. rmode 0 keeps out_ready high, 1 randomises it. A start
  // pulse at cycle 'glitch' (while busy) must be ignored.
  task automatic run_case(input logic [31:0] sd, input int ns, input int mt,
                          input int rmode, input int glitch,
                          output int dcyc, output bit saw_valid);
    bit finished;
    got_q.delete();
    dcyc      = -1;
    saw_valid = 1'b0;
    finished  = 1'b0;
    @(negedge clk);
    seed        = sd;
    num_samples = 16'(ns);
    max_tries   = TRY_W'(mt);
    start       = 1'b1;
    for (int cyc = 1; cyc <= 4000; cyc++) begin
      @(negedge clk);
      start = (cyc == glitch);
      if (cyc == glitch) begin
        seed        = ~sd;
        num_samples = 16'd1;
        max_tries   = TRY_W'(1);
      end
      out_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (out_valid) saw_valid = 1'b1;
      if (out_valid && out_ready) got_q.push_back(out_data);
      if (done && dcyc < 0) dcyc = cyc;
      if (done && !out_valid) begin
        finished = 1'b1;
        break;
      end
    end
    start = 1'b0;
    chki("run_finished", int'(finished), 1);
  endtask

  task automatic cmp_run(input string tag, input int dcyc, input bit check_cyc);
    chki({tag, "_npop"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_pop%0d", tag, i), got_q[i], exp_q[i]);
    chki({tag, "_tries"}, int'(tries_cnt), exp_tries);
    chki({tag, "_accept"}, int'(accept_cnt), exp_acc);
    chki({tag, "_timeout"}, int'(timeout), exp_to);
    chki({tag, "_busy"}, int'(busy), 0);
    if (check_cyc) chki({tag, "_done_cycle"}, dcyc, exp_tries * (K + 1) + 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int               dcyc;
    bit               sv;
    logic [31:0]      sd;
    logic [VEC_W-1:0] c0;
    logic [VEC_W-1:0] q0[$];

    rst         = 1'b1;
    start       = 1'b0;
    seed        = '0;
    num_samples = '0;
    max_tries   = '0;
    out_ready   = 1'b0;
    sat_mode    = 1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cand", cand, '0);
    chk("rst_out_data", out_data, '0);
    chki("rst_out_valid", int'(out_valid), 0);
    chki("rst_busy", int'(busy), 0);
    chki("rst_done", int'(done), 0);
    chki("rst_timeout", int'(timeout), 0);
    chki("rst_tries", int'(tries_cnt), 0);
    chki("rst_accept", int'(accept_cnt), 0);
    @(negedge clk);
    rst = 1'b0;

    // All-accept run
    sat_mode = 1;
    model_run(32'd1, 3, 100, 1);
    run_case(32'd1, 3, 100, 0, 0, dcyc, sv);
    cmp_run("all_accept", dcyc, 1'b1);
    chki("all_accept_done", int'(done), 1);

    // Timeout
    sat_mode = 0;
    sd = $urandom;
    model_run(sd, 4, 5, 0);
    run_case(sd, 4, 5, 0, 0, dcyc, sv);
    cmp_run("timeout", dcyc, 1'b1);
    chki("timeout_no_valid", int'(sv), 0);

    // Zero sample count and zero budget finish at once
    sat_mode = 1;
    run_case($urandom, 0, 10, 0, 0, dcyc, sv);
    chki("zero_ns_cycle", dcyc, 1);
    chki("zero_ns_timeout", int'(timeout), 0);
    chki("zero_ns_tries", int'(tries_cnt), 0);
    run_case($urandom, 5, 0, 0, 0, dcyc, sv);
    chki("zero_mt_cycle", dcyc, 1);
    chki("zero_mt_timeout", int'(timeout), 0);

    // Back-pressure: FIFO fills, CHECK stalls, then drains in order
    sat_mode  = 1;
    out_ready = 1'b0;
    sd        = $urandom;
    model_run(sd, 10, 100, 1);
    @(negedge clk);
    seed        = sd;
    num_samples = 16'd10;
    max_tries   = TRY_W'(100);
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (102) @(negedge clk);
    chki("bp_busy", int'(busy), 1);
    chki("bp_done", int'(done), 0);
    chki("bp_valid", int'(out_valid), 1);
    chki("bp_tries", int'(tries_cnt), 8);
    chki("bp_accept", int'(accept_cnt), 8);
    c0 = cand;
    repeat (5) @(negedge clk);
    chk("bp_cand_stable", cand, c0);
    chk("bp_head", out_data, exp_q[0]);
    chk("bp_stalled_cand", cand, exp_q[8]);
    got_q.delete();
    dcyc = -1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (out_valid && out_ready) got_q.push_back(out_data);
      if (done && !out_valid) begin
        dcyc = cyc;
        break;
      end
    end
    chki("bp_drained", int'(dcyc >= 0), 1);
    cmp_run("bp", 0, 1'b0);

    // Seed 0 behaves as seed 1; sat follows cand[0]
    sat_mode = 2;
    model_run(32'd1, 4, 200, 2);
    run_case(32'd0, 4, 200, 1, 0, dcyc, sv);
    cmp_run("seed0", dcyc, 1'b0);
    q0 = got_q;
    run_case(32'd1, 4, 200, 1, 0, dcyc, sv);
    cmp_run("seed1", dcyc, 1'b0);
    chki("seed_eq_n", q0.size(), got_q.size());
    for (int i = 0; i < q0.size() && i < got_q.size(); i++) begin
      chk($sformatf("seed_eq%0d", i), q0[i], got_q[i]);
      chki($sformatf("seed_bit0_%0d", i), int'(got_q[i][0]), 1);
    end

    // Randomised runs with random back-pressure and an ignored mid-run start
    for (int r = 0; r < 6; r++) begin
      int ns, mt;
      sd = $urandom;
      ns = $urandom_range(1, 5);
      mt = $urandom_range(1, 30);
      model_run(sd, ns, mt, 2);
      run_case(sd, ns, mt, 1, 3, dcyc, sv);
      cmp_run($sformatf("rand%0d", r), dcyc, 1'b0);
    end

    // Reset mid-FILL with three FIFO entries
    sat_mode  = 1;
    out_ready = 1'b0;
    @(negedge clk);
    seed        = $urandom;
    num_samples = 16'd10;
    max_tries   = TRY_W'(100);
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (37) @(negedge clk);
    chki("mid_valid_before", int'(out_valid), 1);
    chki("mid_accept_before", int'(accept_cnt), 3);
    #2 rst = 1'b1;
    #1;
    chki("mid_rst_valid", int'(out_valid), 0);
    chki("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_cand", cand, '0);
    chk("mid_rst_out_data", out_data, '0);
    @(posedge clk);
    #1;
    chki("mid_rst_valid_next", int'(out_valid), 0);
    chki("mid_rst_busy_next", int'(busy), 0);
    chki("mid_rst_done_next", int'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    model_run(32'd7, 2, 50, 1);
    run_case(32'd7, 2, 50, 0, 0, dcyc, sv);
    cmp_run("after_rst", dcyc, 1'b1);

`ifdef SAMPLER_DEDUP_EN
    // Repeated satisfying candidate is not pushed
    begin
      logic [VEC_W-1:0] fixed_c;
      fixed_c = {VEC_W{1'b0}} | 64'hA5A5_0F0F_1234_5679;
      sat_mode = 1;
      force dut.cand = fixed_c;
      run_case(32'd5, 2, 2, 0, 0, dcyc, sv);
      release dut.cand;
      chki("dedup_tries", int'(tries_cnt), 2);
      chki("dedup_accept", int'(accept_cnt), 1);
      chki("dedup_timeout", int'(timeout), 1);
      chki("dedup_npop", got_q.size(), 1);
      if (got_q.size() > 0) chk("dedup_pop0", got_q[0], fixed_c);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
